pll_reset_sequencer: RTL and testbench

// - Controller-side counterpart of the PLL wrapper. Drives the PLL's rst input and consumes its locked output.
// - Pulses PLL reset, waits for lock with a timeout, requires lock to stay stable, then releases system reset.
// - Loss of lock or a relock request restarts the sequence. Bounded retries end in a sticky FAIL.
// - Runs on the free-running 50 MHz reference, so it works while PLL outputs are dead.

---
 rtl/pll_reset_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose
//   Controller-side companion of the PLL wrapper. It pulses the PLL reset,
//   waits (with a timeout) for the PLL to report lock, requires that lock to
//   hold for a stable window, and only then releases the system reset.
//   A loss of lock while running, or a relock request, restarts the sequence.
//   Repeated lock timeouts end in a sticky FAIL state that only a relock
//   request (or rst) leaves.
//   The block runs from the free-running reference clock, so it keeps working
//   while the PLL outputs are dead.
//
// Parameters
//   RST_PULSE_CYCLES  refclk cycles pll_rst_o is held high per attempt (>=1)
//   LOCK_TIMEOUT      refclk cycles allowed in WAIT_LOCK per attempt
//   LOCK_STABLE       consecutive synchronised-lock cycles needed before RUN
//   MAX_RETRIES       failed attempts that lead to FAIL (1..15)
//
// Ports
//   refclk_i         in   1  reference clock, sole clock of this block
//   rst_i            in   1  asynchronous, active-high reset
//   pll_locked_i     in   1  PLL locked flag, asynchronous to refclk_i
//   relock_req_i     in   1  single-cycle request to restart the sequence
//   pll_rst_o        out  1  drives the PLL reset input
//   sys_reset_o      out  1  active-high system reset request (low only in RUN)
//   ready_o          out  1  high only in RUN
//   fail_o           out  1  high only in FAIL
//   lost_lock_o      out  1  one-cycle pulse when lock drops in RUN
//   retry_cnt_o      out  4  failed attempts since last success / relock
//   lock_loss_cnt_o  out  8  saturating count of lock-loss events
//
// Build option
//   LOCK_LOSS_COUNT_EN  when defined, lock_loss_cnt_o counts lost_lock_o
//                       pulses and saturates at 255 (cleared only by rst_i).
//                       When undefined, lock_loss_cnt_o is tied to zero and
//                       no counter is built.
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 50000,
    parameter int LOCK_STABLE      = 1024,
    parameter int MAX_RETRIES      = 7
) (
    input  logic       refclk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       relock_req_i,
    output logic       pll_rst_o,
    output logic       sys_reset_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic       lost_lock_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] lock_loss_cnt_o
);

    // -------------------------------------------------------------------------
    // Shared cycle counter sizing: wide enough for the longest timed state.
    // -------------------------------------------------------------------------
    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_RESET_PLL = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABILIZE = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    // -------------------------------------------------------------------------
    // Lock synchroniser: pll_locked_i is asynchronous, two flops before use.
    // -------------------------------------------------------------------------
    logic lk_meta_q;
    logic lk_q;

    always_ff @(posedge refclk_i or posedge rst_i) begin
        if (rst_i) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked_i;
            lk_q      <= lk_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       retry_q;
    logic [3:0]       retry_d;
    logic [3:0]       retry_inc;
    logic             lost_d;

    assign retry_inc = retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        retry_d = retry_q;
        lost_d  = 1'b0;

        case (state_q)
            ST_RESET_PLL: begin
                // The reset pulse always runs to completion; a relock request
                // here would only restart what is already happening.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end

            ST_WAIT_LOCK: begin
                cnt_d = cnt_q + 1'b1;
                if (relock_req_i) begin
                    state_d = ST_RESET_PLL;
                    retry_d = 4'd0;
                end else if (lk_q) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
                end
            end

            ST_STABILIZE: begin
                cnt_d = cnt_q + 1'b1;
                if (relock_req_i) begin
                    state_d = ST_RESET_PLL;
                    retry_d = 4'd0;
                end else if (!lk_q) begin
                    // A glitch is not a failed attempt: just wait for lock
                    // again with a fresh timeout window.
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Loss of lock and relock can coincide; both lead to
                // RESET_PLL, the pulse is still reported and retries stay 0.
                if (!lk_q) begin
                    lost_d  = 1'b1;
                    state_d = ST_RESET_PLL;
                end
                if (relock_req_i) begin
                    state_d = ST_RESET_PLL;
                    retry_d = 4'd0;
                end
            end

            ST_FAIL: begin
                if (relock_req_i) begin
                    state_d = ST_RESET_PLL;
                    retry_d = 4'd0;
                end
            end

            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase

        // A successful lock wipes the retry history.
        if (state_d == ST_RUN) begin
            retry_d = 4'd0;
        end

        // The single counter restarts on every state change.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge refclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RESET_PLL;
            cnt_q   <= '0;
            retry_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs, decoded from the next state so that every output
    // changes on the same edge as the state it belongs to.
    // -------------------------------------------------------------------------
    logic pll_rst_q;
    logic sys_reset_q;
    logic ready_q;
    logic fail_q;
    logic lost_lock_q;

    always_ff @(posedge refclk_i or posedge rst_i) begin
        if (rst_i) begin
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            pll_rst_q   <= (state_d == ST_RESET_PLL);
            sys_reset_q <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
            lost_lock_q <= lost_d;
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign sys_reset_o = sys_reset_q;
    assign ready_o     = ready_q;
    assign fail_o      = fail_q;
    assign lost_lock_o = lost_lock_q;
    assign retry_cnt_o = retry_q;

    // -------------------------------------------------------------------------
    // Optional lock-loss event counter
    // -------------------------------------------------------------------------
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q;

    // Counts on the same edge the lost_lock pulse is issued; holds at 255.
    always_ff @(posedge refclk_i or posedge rst_i) begin
        if (rst_i) begin
            loss_cnt_q <= 8'd0;
        end else if (lost_d && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`else
    assign lock_loss_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer with RST_PULSE_CYCLES=4,
// LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=3.
//
// Timing convention: inputs are driven and outputs sampled 1 time unit after a
// rising edge. An input driven after edge N is captured by the first
// synchroniser flop at N+1, appears as lk at N+2, and the FSM reacts on N+3.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int P_RST = 4;
    localparam int P_TO  = 20;
    localparam int P_STB = 8;
    localparam int P_MAX = 3;

`ifdef LOCK_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic       lost_lock;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int tests = 0;
    int fails = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES(P_RST),
        .LOCK_TIMEOUT    (P_TO),
        .LOCK_STABLE     (P_STB),
        .MAX_RETRIES     (P_MAX)
    ) dut (
        .refclk_i       (clk),
        .rst_i          (rst),
        .pll_locked_i   (pll_locked),
        .relock_req_i   (relock_req),
        .pll_rst_o      (pll_rst),
        .sys_reset_o    (sys_reset),
        .ready_o        (ready),
        .fail_o         (fail),
        .lost_lock_o    (lost_lock),
        .retry_cnt_o    (retry_cnt),
        .lock_loss_cnt_o(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected saturating lock-loss count after n events.
    function automatic logic [7:0] exp_loss(input int n);
        if (!CNT_EN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        tick(2);
        tests++;
        if ({pll_rst, sys_reset, ready, fail, lost_lock} !== 5'b11000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 11000", {pll_rst, sys_reset, ready, fail, lost_lock});
        end
        tests++;
        if (retry_cnt !== 4'd0) begin
            fails++;
            $display("FAIL reset_retry: got %0d want 0", retry_cnt);
        end
        tests++;
        if (lock_loss_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_loss_cnt: got %0d want 0", lock_loss_cnt);
        end
        $display("[TB] reset: flags=%b retry=%0d", {pll_rst, sys_reset, ready, fail, lost_lock}, retry_cnt);
    endtask

    // ------------------------------------------------------------------
    // Release rst; pll_rst falls on the 4th edge (E0). Lock driven after E9,
    // lk at E11, STABILIZE at E12, RUN at E20.
    task automatic test_nominal();
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        tests++;
        if (pll_rst !== 1'b1) begin
            fails++;
            $display("FAIL nominal_pulse_high: got %b want 1", pll_rst);
        end
        tick(1);
        tests++;
        if (pll_rst !== 1'b0) begin
            fails++;
            $display("FAIL nominal_pulse_fall: got %b want 0", pll_rst);
        end
        tick(9);
        pll_locked = 1'b1;
        tick(10);
        tests++;
        if ({ready, sys_reset} !== 2'b01) begin
            fails++;
            $display("FAIL nominal_early_ready: got ready,sys_reset=%b want 01", {ready, sys_reset});
        end
        tick(1);
        tests++;
        if ({ready, sys_reset, retry_cnt} !== {2'b10, 4'd0}) begin
            fails++;
            $display("FAIL nominal_run: got ready=%b sys_reset=%b retry=%0d want 1 0 0", ready, sys_reset, retry_cnt);
        end
        $display("[TB] nominal: ready=%b sys_reset=%b retry=%0d", ready, sys_reset, retry_cnt);
    endtask

    // ------------------------------------------------------------------
    // Lock dropped after F0 -> lost_lock and RESET_PLL at F3, pulse F3..F6.
    task automatic test_loss();
        pll_locked = 1'b0;
        tick(2);
        tests++;
        if ({lost_lock, ready} !== 2'b01) begin
            fails++;
            $display("FAIL loss_early: got lost,ready=%b want 01", {lost_lock, ready});
        end
        tick(1);
        tests++;
        if ({lost_lock, sys_reset, ready, pll_rst} !== 4'b1101) begin
            fails++;
            $display("FAIL loss_edge: got lost,sys,ready,pll_rst=%b want 1101", {lost_lock, sys_reset, ready, pll_rst});
        end
        tests++;
        if (lock_loss_cnt !== exp_loss(1)) begin
            fails++;
            $display("FAIL loss_count: got %0d want %0d", lock_loss_cnt, exp_loss(1));
        end
        tick(1);
        tests++;
        if ({lost_lock, pll_rst} !== 2'b01) begin
            fails++;
            $display("FAIL loss_pulse_width: got lost,pll_rst=%b want 01", {lost_lock, pll_rst});
        end
        tick(2);
        tests++;
        if (pll_rst !== 1'b1) begin
            fails++;
            $display("FAIL loss_rst_hold: got %b want 1", pll_rst);
        end
        tick(1);
        tests++;
        if (pll_rst !== 1'b0) begin
            fails++;
            $display("FAIL loss_rst_fall: got %b want 0", pll_rst);
        end
        $display("[TB] loss: lock_loss_cnt=%0d", lock_loss_cnt);
    endtask

    // ------------------------------------------------------------------
    // Starts at E0 (pll_rst just fell). STABILIZE at E12, lock low after E15
    // for one cycle -> WAIT_LOCK at E18, STABILIZE at E19, RUN at E27.
    task automatic test_glitch();
        tick(9);
        pll_locked = 1'b1;
        tick(6);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(10);
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL glitch_early_run: got ready=%b want 0", ready);
        end
        tick(1);
        tests++;
        if ({ready, sys_reset, retry_cnt} !== {2'b10, 4'd0}) begin
            fails++;
            $display("FAIL glitch_run: got ready=%b sys_reset=%b retry=%0d want 1 0 0", ready, sys_reset, retry_cnt);
        end
        $display("[TB] glitch: ready=%b retry=%0d", ready, retry_cnt);
    endtask

    // ------------------------------------------------------------------
    // Relock from RUN with lock still seen (no lost_lock), then lock held 0
    // until three timeouts end in FAIL.
    task automatic test_timeout();
        relock_req = 1'b1;
        pll_locked = 1'b0;
        tick(1);
        relock_req = 1'b0;
        tests++;
        if ({lost_lock, ready, pll_rst, sys_reset, retry_cnt} !== {4'b0011, 4'd0}) begin
            fails++;
            $display("FAIL relock_run: got lost,ready,pll_rst,sys=%b retry=%0d want 0011 0",
                     {lost_lock, ready, pll_rst, sys_reset}, retry_cnt);
        end
        tick(3);
        tests++;
        if (pll_rst !== 1'b1) begin
            fails++;
            $display("FAIL timeout_first_pulse: got %b want 1", pll_rst);
        end
        tick(1);
        tests++;
        if (pll_rst !== 1'b0) begin
            fails++;
            $display("FAIL timeout_first_fall: got %b want 0", pll_rst);
        end
        for (int a = 1; a <= P_MAX; a++) begin
            tick(P_TO - 1);
            tests++;
            if ({pll_rst, fail, retry_cnt} !== {2'b00, 4'(a - 1)}) begin
                fails++;
                $display("FAIL timeout_wait_%0d: got pll_rst=%b fail=%b retry=%0d want 0 0 %0d",
                         a, pll_rst, fail, retry_cnt, a - 1);
            end
            tick(1);
            tests++;
            if (retry_cnt !== 4'(a)) begin
                fails++;
                $display("FAIL timeout_retry_%0d: got %0d want %0d", a, retry_cnt, a);
            end
            if (a < P_MAX) begin
                tests++;
                if (pll_rst !== 1'b1) begin
                    fails++;
                    $display("FAIL timeout_pulse_start_%0d: got %b want 1", a, pll_rst);
                end
                tick(P_RST - 1);
                tests++;
                if (pll_rst !== 1'b1) begin
                    fails++;
                    $display("FAIL timeout_pulse_hold_%0d: got %b want 1", a, pll_rst);
                end
                tick(1);
                tests++;
                if (pll_rst !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_pulse_end_%0d: got %b want 0", a, pll_rst);
                end
            end else begin
                tests++;
                if ({fail, pll_rst, sys_reset, ready} !== 4'b1010) begin
                    fails++;
                    $display("FAIL timeout_fail_entry: got fail,pll_rst,sys,ready=%b want 1010",
                             {fail, pll_rst, sys_reset, ready});
                end
            end
            $display("[TB] timeout attempt %0d: retry=%0d fail=%b", a, retry_cnt, fail);
        end
        tick(30);
        tests++;
        if ({fail, pll_rst, sys_reset, retry_cnt} !== {3'b101, 4'd3}) begin
            fails++;
            $display("FAIL fail_sticky: got fail,pll_rst,sys=%b retry=%0d want 101 3",
                     {fail, pll_rst, sys_reset}, retry_cnt);
        end
    endtask

    // ------------------------------------------------------------------
    // Relock out of FAIL (K0), relock during RESET_PLL ignored, then an
    // asynchronous rst while in STABILIZE.
    task automatic test_relock_fail_and_rst();
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        pll_locked = 1'b1;
        tests++;
        if ({fail, pll_rst, sys_reset, retry_cnt} !== {3'b011, 4'd0}) begin
            fail_report_relock: begin
                fails++;
                $display("FAIL relock_from_fail: got fail,pll_rst,sys=%b retry=%0d want 011 0",
                         {fail, pll_rst, sys_reset}, retry_cnt);
            end
        end
        tick(1);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        tick(1);
        tests++;
        if (pll_rst !== 1'b1) begin
            fails++;
            $display("FAIL relock_in_reset_hold: got %b want 1", pll_rst);
        end
        tick(1);
        tests++;
        if (pll_rst !== 1'b0) begin
            fails++;
            $display("FAIL relock_in_reset_ignored: got pll_rst=%b want 0", pll_rst);
        end
        // WAIT_LOCK at K4 sees lk, STABILIZE from K5; K7 is mid-window.
        tick(3);
        tests++;
        if ({pll_rst, ready, sys_reset} !== 3'b001) begin
            fails++;
            $display("FAIL stabilize_state: got pll_rst,ready,sys=%b want 001", {pll_rst, ready, sys_reset});
        end
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({pll_rst, sys_reset, ready, fail, lost_lock, retry_cnt, lock_loss_cnt} !== {5'b11000, 4'd0, 8'd0}) begin
            fails++;
            $display("FAIL async_rst: got flags=%b retry=%0d loss=%0d want 11000 0 0",
                     {pll_rst, sys_reset, ready, fail, lost_lock}, retry_cnt, lock_loss_cnt);
        end
        $display("[TB] relock/rst: pll_rst=%b sys_reset=%b", pll_rst, sys_reset);
    endtask

    // ------------------------------------------------------------------
    // 260 lock-loss events from a fresh reset; counter saturates at 255
    // (or stays 0 when the counter is not built).
    task automatic test_saturation();
        bit ok;
        pll_locked = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 260; n++) begin
            for (int k = 0; k < 100 && !ready; k++) tick(1);
            ok = ready;
            pll_locked = 1'b0;
            for (int k = 0; k < 10 && !lost_lock; k++) tick(1);
            ok = ok & lost_lock;
            pll_locked = 1'b1;
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL sat_handshake_%0d: got ready/lost=0 want 1 within bound", n);
                break;
            end
            if (n == 1 || n == 128 || n == 254 || n == 255 || n == 256 || n == 260) begin
                tests++;
                if (lock_loss_cnt !== exp_loss(n)) begin
                    fails++;
                    $display("FAIL sat_count_%0d: got %0d want %0d", n, lock_loss_cnt, exp_loss(n));
                end
                $display("[TB] saturation event %0d: lock_loss_cnt=%0d", n, lock_loss_cnt);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Lock loss and relock seen in the same RUN cycle (F3).
    task automatic test_relock_and_loss();
        bit ok;
        for (int k = 0; k < 100 && !ready; k++) tick(1);
        ok = ready;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL both_reach_run: got ready=0 want 1 within bound");
        end
        pll_locked = 1'b0;
        tick(2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        tests++;
        if ({lost_lock, pll_rst, ready, sys_reset, retry_cnt} !== {4'b1101, 4'd0}) begin
            fails++;
            $display("FAIL both_edge: got lost,pll_rst,ready,sys=%b retry=%0d want 1101 0",
                     {lost_lock, pll_rst, ready, sys_reset}, retry_cnt);
        end
        tests++;
        if (lock_loss_cnt !== exp_loss(261)) begin
            fails++;
            $display("FAIL both_count: got %0d want %0d", lock_loss_cnt, exp_loss(261));
        end
        tick(1);
        tests++;
        if (lost_lock !== 1'b0) begin
            fails++;
            $display("FAIL both_pulse_width: got %b want 0", lost_lock);
        end
        $display("[TB] relock+loss: lost_lock pulse seen, lock_loss_cnt=%0d", lock_loss_cnt);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_loss();
        test_glitch();
        test_timeout();
        test_relock_fail_and_rst();
        test_saturation();
        test_relock_and_loss();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
